// File: rtl/score_calculator_if.sv
// Judgement, control and result bundle between the rhythm-game front end and
// the scoring stage.
interface score_calculator_if;
    logic        clear;
    logic        judge_valid;
    logic [1:0]  judge_type;
    logic [15:0] total_notes;
    logic        start;
    logic        busy;
    logic [19:0] score;
    logic        score_valid;
    logic [15:0] note_count;
    logic [17:0] points;
    logic [15:0] combo;
    logic [15:0] max_combo;

    modport master (
        output clear, judge_valid, judge_type, total_notes, start,
        input  busy, score, score_valid, note_count, points, combo, max_combo
    );

    modport slave (
        input  clear, judge_valid, judge_type, total_notes, start,
        output busy, score, score_valid, note_count, points, combo, max_combo
    );
endinterface

// File: rtl/score_calculator.sv
// Accumulates note judgements and computes floor(1e6 * points / (4 * notes))
// with a one-bit-per-cycle restoring divider.
module score_calculator #(
    parameter int DIV_BITS = 38
) (
    input  logic                clk,
    input  logic                resetn,
    score_calculator_if.slave   bus
);
    localparam int          CNT_W     = $clog2(DIV_BITS + 1);
    localparam logic [19:0] MAX_SCORE = 20'd1_000_000;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t              state, state_nxt;
    logic [DIV_BITS-1:0] num, quo;
    logic [17:0]         divisor;
    logic [17:0]         rem;
    logic [CNT_W-1:0]    cnt;

    logic        accept;
    logic [2:0]  weight;
    logic [15:0] combo_inc;
    logic [18:0] rem_sh;
    logic        fits;
    logic [19:0] quo_sat;

    always_comb begin
        accept    = bus.judge_valid && (bus.note_count < bus.total_notes);
        combo_inc = bus.combo + 16'd1;
        case (bus.judge_type)
            2'd1:    weight = 3'd2;
            2'd2:    weight = 3'd3;
            2'd3:    weight = 3'd4;
            default: weight = 3'd0;
        endcase
        rem_sh  = {rem, num[DIV_BITS-1]};
        fits    = rem_sh >= {1'b0, divisor};
        // Quotient cannot exceed 1e6 for legal inputs; clamp anyway.
        quo_sat = (|quo[DIV_BITS-1:20]) ? MAX_SCORE : quo[19:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.total_notes != 16'd0) ? DIV : DONE;
            DIV:  if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.note_count  <= '0;
            bus.points      <= '0;
            bus.combo       <= '0;
            bus.max_combo   <= '0;
            bus.score       <= '0;
            bus.score_valid <= 1'b0;
            num             <= '0;
            quo             <= '0;
            divisor         <= '0;
            rem             <= '0;
            cnt             <= '0;
        end else if (bus.clear) begin
            bus.note_count  <= '0;
            bus.points      <= '0;
            bus.combo       <= '0;
            bus.max_combo   <= '0;
            bus.score       <= '0;
            bus.score_valid <= 1'b0;
            num             <= '0;
            quo             <= '0;
            divisor         <= '0;
            rem             <= '0;
            cnt             <= '0;
        end else begin
            bus.score_valid <= 1'b0;
            if (accept) begin
                bus.note_count <= bus.note_count + 16'd1;
                bus.points     <= bus.points + 18'(weight);
                if (bus.judge_type == 2'd0) begin
                    bus.combo <= '0;
                end else begin
                    bus.combo <= combo_inc;
                    if (combo_inc > bus.max_combo) bus.max_combo <= combo_inc;
                end
            end
            case (state)
                IDLE: if (bus.start) begin
                    quo <= '0;
                    rem <= '0;
                    if (bus.total_notes != 16'd0) begin
                        // Snapshot pre-edge points; judgements during DIV don't disturb it.
                        num     <= DIV_BITS'(bus.points) * DIV_BITS'(MAX_SCORE);
                        divisor <= {bus.total_notes, 2'b00};
                        cnt     <= CNT_W'(DIV_BITS);
                    end
                end
                DIV: begin
                    num <= num << 1;
                    quo <= {quo[DIV_BITS-2:0], fits};
                    rem <= fits ? 18'(rem_sh - {1'b0, divisor}) : rem_sh[17:0];
                    cnt <= cnt - CNT_W'(1);
                end
                DONE: begin
                    bus.score       <= quo_sat;
                    bus.score_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_score_calculator.sv
// Scoreboard bench for score_calculator: expected scores queued at start,
// checked with latency when score_valid fires.
module tb_score_calculator;
    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   start_cyc = 0;

    typedef struct { int score; int lat; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int m_nc, m_pts, m_combo, m_max;

    score_calculator_if ifc();
    score_calculator #(.DIV_BITS(38)) dut (.clk(clk), .resetn(resetn), .bus(ifc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn && ifc.score_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid score=%0d cyc=%0d", ifc.score, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (ifc.score !== 20'(mon_e.score)) begin
                    errors++;
                    $display("FAIL score got=%0d exp=%0d", ifc.score, mon_e.score);
                end
                checks++;
                if (cyc - start_cyc !== mon_e.lat) begin
                    errors++;
                    $display("FAIL latency got=%0d exp=%0d", cyc - start_cyc, mon_e.lat);
                end
            end
        end
    end

    function automatic int exp_score(int pts, int tn);
        longint n;
        if (tn == 0) return 0;
        n = longint'(pts) * 64'd1000000;
        return int'(n / (4 * tn));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input int tn);
        ifc.total_notes = 16'(tn);
        ifc.clear = 1'b1;
        tick();
        ifc.clear = 1'b0;
        m_nc = 0; m_pts = 0; m_combo = 0; m_max = 0;
    endtask

    task automatic judge(input int t);
        ifc.judge_valid = 1'b1;
        ifc.judge_type  = 2'(t);
        tick();
        ifc.judge_valid = 1'b0;
        if (m_nc < int'(ifc.total_notes)) begin
            m_nc++;
            m_pts += (t == 0) ? 0 : t + 1;
            if (t == 0) m_combo = 0;
            else begin
                m_combo++;
                if (m_combo > m_max) m_max = m_combo;
            end
        end
    endtask

    task automatic do_start(input int exp, input int lat);
        exp_t e;
        e.score = exp;
        e.lat   = lat;
        sb.push_back(e);
        ifc.start = 1'b1;
        tick();
        start_cyc = cyc;
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !ifc.busy) break;
            tick();
        end
        checks++;
        if (i == 100) begin
            errors++;
            $display("FAIL %s timeout pending=%0d busy=%0b", name, sb.size(), ifc.busy);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ifc.clear = 1'b0; ifc.judge_valid = 1'b0; ifc.judge_type = 2'd3;
        ifc.total_notes = 16'd4; ifc.start = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ifc.busy, ifc.score_valid, ifc.score, ifc.points, ifc.note_count, ifc.combo, ifc.max_combo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%0b sv=%0b score=%0d pts=%0d nc=%0d", ifc.busy, ifc.score_valid, ifc.score, ifc.points, ifc.note_count);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_all_perfect();
        do_clear(4);
        repeat (4) judge(3);
        checks++;
        if (ifc.points !== 18'd16 || ifc.max_combo !== 16'd4) begin
            errors++;
            $display("FAIL all_perfect_counts pts=%0d exp=16 max=%0d exp=4", ifc.points, ifc.max_combo);
        end
        do_start(1000000, 39);
        checks++;
        if (ifc.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got=%0b exp=1", ifc.busy);
        end
        wait_done("all_perfect");
    endtask

    task automatic test_combo();
        do_clear(4);
        judge(3); judge(3); judge(0); judge(3);
        checks++;
        if (ifc.combo !== 16'd1 || ifc.max_combo !== 16'd2 || ifc.points !== 18'd12) begin
            errors++;
            $display("FAIL combo_counts combo=%0d/1 max=%0d/2 pts=%0d/12", ifc.combo, ifc.max_combo, ifc.points);
        end
        do_start(exp_score(m_pts, 4), 39);
        wait_done("combo");
    endtask

    task automatic test_floor();
        do_clear(3);
        judge(3); judge(3); judge(1);
        checks++;
        if (ifc.points !== 18'(m_pts) || m_pts != 10) begin
            errors++;
            $display("FAIL floor_points got=%0d exp=10", ifc.points);
        end
        do_start(833333, 39);
        wait_done("floor");
    endtask

    task automatic test_drop_and_zero();
        do_clear(2);
        judge(3); judge(3); judge(3);
        checks++;
        if (ifc.note_count !== 16'd2 || ifc.points !== 18'd8 || ifc.combo !== 16'(m_combo)) begin
            errors++;
            $display("FAIL drop nc=%0d/2 pts=%0d/8 combo=%0d/%0d", ifc.note_count, ifc.points, ifc.combo, m_combo);
        end
        do_clear(0);
        judge(3);
        checks++;
        if (ifc.note_count !== 16'd0) begin
            errors++;
            $display("FAIL zero_notes_drop nc=%0d exp=0", ifc.note_count);
        end
        do_start(0, 1);
        wait_done("zero_notes");
    endtask

    task automatic test_back_to_back();
        do_clear(4);
        judge(3); judge(1);
        do_start(exp_score(m_pts, 4), 39);
        repeat (4) tick();
        judge(2);
        repeat (4) tick();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        checks++;
        if (ifc.points !== 18'(m_pts) || m_pts != 9) begin
            errors++;
            $display("FAIL busy_judge_points got=%0d exp=9", ifc.points);
        end
        wait_done("back_to_back");
        repeat (45) tick();
        do_start(exp_score(m_pts, 4), 39);
        wait_done("restart");
    endtask

    task automatic test_async_reset();
        do_clear(4);
        judge(3);
        do_start(0, 0);
        void'(sb.pop_back());
        repeat (10) tick();
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({ifc.busy, ifc.score, ifc.points, ifc.note_count, ifc.max_combo} !== '0) begin
            errors++;
            $display("FAIL async_reset busy=%0b score=%0d pts=%0d nc=%0d", ifc.busy, ifc.score, ifc.points, ifc.note_count);
        end
        @(negedge clk);
        resetn = 1'b1;
        m_nc = 0; m_pts = 0; m_combo = 0; m_max = 0;
        tick();
    endtask

    task automatic test_clear_abort();
        do_clear(4);
        judge(3);
        do_start(250000, 39);
        wait_done("pre_abort");
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        repeat (19) tick();
        ifc.clear = 1'b1;
        tick();
        ifc.clear = 1'b0;
        checks++;
        if (ifc.busy !== 1'b0 || ifc.score !== 20'd0 || ifc.points !== 18'd0) begin
            errors++;
            $display("FAIL clear_abort busy=%0b/0 score=%0d/0 pts=%0d/0", ifc.busy, ifc.score, ifc.points);
        end
        repeat (50) tick();
        checks++;
        if (ifc.score !== 20'd0) begin
            errors++;
            $display("FAIL clear_score_hold got=%0d exp=0", ifc.score);
        end
    endtask

    initial begin
        m_nc = 0; m_pts = 0; m_combo = 0; m_max = 0;
        test_reset();
        test_all_perfect();
        test_combo();
        test_floor();
        test_drop_and_zero();
        test_back_to_back();
        test_async_reset();
        test_clear_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_calculator.md
# score_calculator

Upstream scoring stage for the rhythm game. It accumulates per-note judgements (miss/good/great/perfect) into a weighted point total and tracks combo statistics. On request, it computes the normalised score `floor(1_000_000 × points / (4 × total_notes))` with a sequential restoring divider. The registered 20-bit `score` feeds `rating_decoder` directly, so an all-perfect run must yield exactly 1,000,000.

## Interface
Parameters:
- `DIV_BITS`, default 38: numerator width and number of divider iterations. Must be ≥ 38.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `clear` in 1: start a new song; zeroes all state.
- `judge_valid` in 1: one judgement this cycle.
- `judge_type` in 2: 0 = miss, 1 = good, 2 = great, 3 = perfect.
- `total_notes` in 16: note count of the chart; must be stable from `clear` to `score_valid`.
- `start` in 1: request a score computation.
- `busy` out 1: division in progress.
- `score` out 20: last computed score, 0..1,000,000; goes to `rating_decoder`.
- `score_valid` out 1: one-cycle pulse when `score` updates.
- `note_count` out 16: judgements accepted so far.
- `points` out 18: weighted sum.
- `combo` out 16: current combo.
- `max_combo` out 16: best combo so far.

## Operation
- Reset: every output and internal register is 0, and the state machine is IDLE.
- Judgement weights: miss 0, good 2, great 3, perfect 4. Maximum points = 4 × `total_notes`, which needs at most 18 bits.
- Accepting a judgement (`judge_valid` = 1, `clear` = 0, `note_count` < `total_notes`):
  - `note_count` += 1 and `points` += weight.
  - Non-miss: `combo` += 1. `max_combo` <= max(`max_combo`, new `combo`).
  - Miss: `combo` <= 0.
- Judgements when `note_count` == `total_notes` are dropped silently, with no counter change.
- Judgements are accepted in every state, including while `busy`. The divider works on a snapshot.
- `clear` has priority over everything:
  - Next cycle, all counters, `score`, `busy` and `score_valid` are 0, and the state is IDLE.
  - A division in flight is aborted and no `score_valid` is emitted.
- State machine IDLE / DIV / DONE:
  - **IDLE**, `start` = 1, `total_notes` ≠ 0: snapshot numerator = `points` × 1,000,000 (`DIV_BITS` wide, constant multiply) and divisor = `total_notes` × 4. Clear the quotient and remainder, load iteration counter = `DIV_BITS`, go to DIV.
  - **IDLE**, `start` = 1, `total_notes` = 0: go to DONE with quotient 0; no division.
  - **DIV**: one restoring step per cycle, MSB first:
    - remainder = {remainder, next numerator bit}.
    - If remainder ≥ divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
    - Decrement the counter; at 0, go to DONE.
  - **DONE**: `score` <= quotient[19:0], `score_valid` = 1, then go to IDLE.
- `start` in DIV or DONE is ignored. No queuing.
- The quotient is guaranteed < 2^20 because `points` ≤ 4 × `total_notes`. Saturate `score` to 1,000,000 if the upper quotient bits are ever nonzero.
- `score` holds its value until the next DONE, `clear`, or reset.

## Timing
- `start` sampled at edge E0 with `total_notes` ≠ 0:
  - `busy` = 1 from E0 through the edge that updates `score`.
  - DIV steps run on edges E1..E38, DONE on E39.
  - `score` and `score_valid` are registered at E39; `busy` drops at E39.
  - Start-to-score latency is `DIV_BITS` + 1 = 39 clocks.
- `total_notes` = 0: `score` = 0 and `score_valid` = 1 at E1. Latency 1.
- A judgement arriving in the same cycle as `start` is not included in the snapshot; the snapshot uses the pre-edge `points`.
- `score_valid` lasts exactly one cycle. `busy` is low in the cycle `score_valid` is high, so back-to-back `start` is accepted then.
- `resetn` is asynchronous and asserts immediately mid-division. Deassertion is synchronised externally.

## Test plan
- `total_notes` = 4, four perfects, then `start` → `points` = 16, `score_valid` 39 clocks after `start`, `score` = 1,000,000, `max_combo` = 4.
- `total_notes` = 4; judgements perfect, perfect, miss, perfect → `combo` = 1, `max_combo` = 2, `points` = 12. `start` → `score` = 750,000.
- `total_notes` = 3; perfect, perfect, good → `points` = 10. `start` → `score` = 833,333 (floor).
- `total_notes` = 2; 3 perfects sent → third dropped, `note_count` = 2, `points` = 8. `start` with `total_notes` = 0 after a fresh `clear` → `score` = 0 and `score_valid` one cycle after `start`.
- `start` at E0, judgement great at E5 while `busy`, second `start` at E10 → score reflects the pre-E0 points only; the second `start` is ignored; `points` includes the great.
- `clear` at E20 of a division → `busy` = 0 at E21, no `score_valid` ever, `score` = 0. Asynchronous `resetn` pulse mid-DIV → all outputs 0 immediately.
